fifo_buffer_param: RTL
======================

# fifo_buffer_param

Parametrised synchronous FIFO: dual-port storage, read/write pointer management, fill-level accounting and status/error flags in one clock domain. It supersedes the fixed 8-bit × 16-entry storage array plus external pointer logic, and is the standard elastic buffer between producer and consumer stages in the datapath.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 2)
- AF_THRESH, 2**ADDR_W-2, almost_full asserts when level ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when level ≤ AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data updated this cycle (one-cycle pulse)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_THRESH
- almost_empty  out  1  level ≤ AE_THRESH
- level  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write rejected since last err_clr
- underflow  out  1  sticky: read rejected since last err_clr
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Pointers wptr/rptr are ADDR_W+1 bits; low ADDR_W bits address storage, MSB is wrap bit. Empty: pointers equal. Full: low bits equal, MSBs differ. Both wrap modulo 2**(ADDR_W+1).
- Accept rules (evaluated on registered state at the clock edge):
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_acc)
- wr_acc: mem[wptr low] ← wr_data, wptr += 1. rd_acc: rd_data ← mem[rptr low], rptr += 1, rd_valid = 1 next cycle.
- level: +1 on wr_acc only, −1 on rd_acc only, unchanged if both or neither.
- Full with simultaneous read+write: both accepted, level stays DEPTH.
- Empty with simultaneous read+write: write accepted, read rejected (no fall-through); underflow sets.
- wr_en && !wr_acc → overflow sets; rd_en && !rd_acc → underflow sets. Data and pointers unchanged for the rejected side.
- err_clr clears both sticky flags; a new error in the same cycle wins (flag stays 1).
- rd_data holds its last value when no read is accepted.
- No storage reset: memory contents after reset are undefined; only pointers/flags reset.

## Timing
- Reset (rst_n low, async assert, sync release by system): wptr = rptr = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0. Reset mid-operation discards all contents.
- Write-to-flag latency: 1 cycle (all status outputs registered or decoded from registered pointers/level).
- Read latency: rd_data/rd_valid valid 1 cycle after the accepting edge.
- Write-to-read: a word written at edge N is readable by a request sampled at edge N+1, appearing at N+2.
- Throughput: one write and one read per cycle sustained when 0 < level < DEPTH.

## Structure
- Package fifo_pkg: default DATA_W/ADDR_W constants, function computing DEPTH from ADDR_W, pointer/level width helpers.
- Sub-module fifo_mem_dp: parametrised DATA_W × 2**ADDR_W storage, synchronous write port, registered read port with read enable; no reset on the array.
- Top holds pointers, level counter, flag logic, sticky errors.

## Test plan
- Reset then fill: 16 writes 0x00..0x0F (defaults) → full=1 after 16th, almost_full=1 after 14th, level=16; 17th write → overflow=1, mem unchanged.
- Drain: 16 reads → rd_data 0x00..0x0F in order, each 1 cycle after rd_en; empty=1 after last; extra read → underflow=1, rd_valid=0.
- Wrap: 10 writes/10 reads, repeated 4 times → pointers wrap past 31→0, data order intact, level returns 0.
- Full + simultaneous rd/wr: at level 16 write 0xAA with read → both accepted, rd_data=oldest, level=16, overflow=0.
- Empty + simultaneous rd/wr: at level 0 write 0x55 with read → level=1, underflow=1, rd_valid=0; err_clr next cycle → underflow=0.
- Reset mid-operation: at level 7 assert rst_n low asynchronously → all outputs to reset values immediately, level=0 after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Pointers and the level counter both carry one extra bit: wrap flag / value DEPTH.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port storage: synchronous write, registered read with enable. Array is not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-address read/write (full FIFO, both accepted) returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// Synchronous FIFO: pointer/level management, status flags and sticky error flags.
module fifo_buffer_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned AF_THRESH = depth_of(ADDR_W) - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned PtrW = ptr_w(ADDR_W);
  localparam logic [PtrW-1:0] AfThr = PtrW'(AF_THRESH);
  localparam logic [PtrW-1:0] AeThr = PtrW'(AE_THRESH);

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic            rd_valid_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic            rd_acc, wr_acc;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) && (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wptr_d      = wr_acc ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d      = rd_acc ? rptr_q + PtrW'(1) : rptr_q;
    level_d     = level_q;
    if (wr_acc && !rd_acc) begin
      level_d = level_q + PtrW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - PtrW'(1);
    end
    // A fresh error beats a clear in the same cycle.
    overflow_d  = (overflow_q && !err_clr) || (wr_en && !wr_acc);
    underflow_d = (underflow_q && !err_clr) || (rd_en && !rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign almost_full  = (level_q >= AfThr);
  assign almost_empty = (level_q <= AeThr);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
